// File: rtl/mtimer_multi_if.sv
// Wishbone classic slave bus bundle for mtimer_multi; signal names keep the
// original port names so existing connections map one-to-one.
interface mtimer_multi_if;
  logic        stb_i;
  logic        cyc_i;
  logic [31:0] adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic        we_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        rty_o;

  modport slave (
    input  stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
    output dat_o, ack_o, err_o, rty_o
  );

  modport master (
    output stb_i, cyc_i, adr_i, sel_i, dat_i, we_i,
    input  dat_o, ack_o, err_o, rty_o
  );
endinterface

// File: rtl/mtimer_multi.sv
// Machine timer: 64-bit mtime with 16-bit prescaler, NUM_CMP compare channels
// with W1C pending/IE masking, behind a single-cycle-response Wishbone slave.
module mtimer_multi #(
  parameter logic [31:0] BASE_ADDRESS = 32'h0,
  parameter int unsigned NUM_CMP      = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  mtimer_multi_if.slave      wb,
  output logic [NUM_CMP-1:0] irq_o,
  output logic               irq_any_o
);

  localparam int unsigned WIN = 32 + 8 * NUM_CMP;

  logic [63:0]        mtime_q, mtime_d;
  logic [15:0]        pcnt_q, pcnt_d;
  logic [31:0]        shadow_q, shadow_d;
  logic               run_q, run_d;
  logic [15:0]        div_q, div_d;
  logic [NUM_CMP-1:0] ie_q, ie_d;
  logic [NUM_CMP-1:0] pend_q, pend_d;
  logic [63:0]        cmp_q [NUM_CMP];
  logic [63:0]        cmp_d [NUM_CMP];
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic [31:0]        rdata_q, rdata_d;

  logic [31:0]        off;
  logic               addressed, req, bad, wr, rd, tick;
  logic [31:0]        wmask;
  logic [NUM_CMP-1:0] set, w1c;

  function automatic logic [31:0] wmerge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  always_comb begin
    off       = wb.adr_i - BASE_ADDRESS;
    addressed = (wb.adr_i >= BASE_ADDRESS) && (off < WIN);
    req       = wb.stb_i && wb.cyc_i && !ack_q && !err_q && addressed;
    bad       = (off[1:0] != 2'b00) || ((off >= 32'h14) && (off < 32'h20));
    wr        = req && !bad && wb.we_i;
    rd        = req && !bad && !wb.we_i;
    for (int unsigned b = 0; b < 4; b++) wmask[8*b +: 8] = {8{wb.sel_i[b]}};

    tick     = run_q && (pcnt_q == div_q);
    mtime_d  = mtime_q + {63'd0, tick};
    pcnt_d   = !run_q ? pcnt_q : (tick ? '0 : pcnt_q + 16'd1);
    shadow_d = shadow_q;
    run_d    = run_q;
    div_d    = div_q;
    ie_d     = ie_q;
    cmp_d    = cmp_q;
    rdata_d  = '0;
    w1c      = '0;
    for (int unsigned n = 0; n < NUM_CMP; n++) set[n] = (mtime_q >= cmp_q[n]);

    // Register writes land on top of the tick increment so written bytes win.
    if (wr) begin
      if (off == 32'h00) mtime_d[31:0]  = wmerge(mtime_d[31:0], wb.dat_i, wmask);
      if (off == 32'h04) mtime_d[63:32] = wmerge(mtime_d[63:32], wb.dat_i, wmask);
      if (off == 32'h08) begin
        run_d  = wmask[0] ? wb.dat_i[0] : run_q;
        div_d  = (div_q & ~wmask[31:16]) | (wb.dat_i[31:16] & wmask[31:16]);
        pcnt_d = '0;
      end
      if (off == 32'h0C)
        ie_d = (ie_q & ~wmask[NUM_CMP-1:0]) | (wb.dat_i[NUM_CMP-1:0] & wmask[NUM_CMP-1:0]);
      if (off == 32'h10) w1c = wb.dat_i[NUM_CMP-1:0] & wmask[NUM_CMP-1:0];
      for (int unsigned n = 0; n < NUM_CMP; n++) begin
        if (off == 32'h20 + 8*n) cmp_d[n][31:0]  = wmerge(cmp_q[n][31:0], wb.dat_i, wmask);
        if (off == 32'h24 + 8*n) cmp_d[n][63:32] = wmerge(cmp_q[n][63:32], wb.dat_i, wmask);
      end
    end

    pend_d = (pend_q & ~w1c) | set;

    // Reading LO snapshots HI so a following HI read pairs with it.
    if (rd) begin
      if (off == 32'h00) begin
        rdata_d  = mtime_q[31:0];
        shadow_d = mtime_q[63:32];
      end
      if (off == 32'h04) rdata_d = shadow_q;
      if (off == 32'h08) rdata_d = {div_q, 15'd0, run_q};
      if (off == 32'h0C) rdata_d[NUM_CMP-1:0] = ie_q;
      if (off == 32'h10) rdata_d[NUM_CMP-1:0] = pend_q;
      for (int unsigned n = 0; n < NUM_CMP; n++) begin
        if (off == 32'h20 + 8*n) rdata_d = cmp_q[n][31:0];
        if (off == 32'h24 + 8*n) rdata_d = cmp_q[n][63:32];
      end
    end

    ack_d = req && !bad;
    err_d = req && bad;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mtime_q  <= '0;
      pcnt_q   <= '0;
      shadow_q <= '0;
      run_q    <= 1'b1;
      div_q    <= '0;
      ie_q     <= '0;
      pend_q   <= '0;
      for (int unsigned n = 0; n < NUM_CMP; n++) cmp_q[n] <= '1;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      mtime_q  <= mtime_d;
      pcnt_q   <= pcnt_d;
      shadow_q <= shadow_d;
      run_q    <= run_d;
      div_q    <= div_d;
      ie_q     <= ie_d;
      pend_q   <= pend_d;
      cmp_q    <= cmp_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign wb.ack_o   = ack_q;
  assign wb.err_o   = err_q;
  assign wb.rty_o   = 1'b0;
  assign wb.dat_o   = (ack_q && !wb.we_i) ? rdata_q : '0;
  assign irq_o      = pend_q & ie_q;
  assign irq_any_o  = |irq_o;

endmodule

// File: tb/tb_mtimer_multi.sv
// Bench for mtimer_multi: directed scenarios plus random register traffic,
// every cycle compared against a register-level reference model.
module tb_mtimer_multi;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int unsigned NC   = 4;
  localparam int unsigned WIN  = 32 + 8 * NC;
  localparam logic [31:0] LOW  = (32'd1 << NC) - 32'd1;

  localparam logic [31:0] R_LO = 32'h00, R_HI = 32'h04, R_CTRL = 32'h08,
                          R_IE = 32'h0C, R_PEND = 32'h10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NC-1:0] irq;
  logic          irq_any;

  mtimer_multi_if bus ();

  mtimer_multi #(.BASE_ADDRESS(BASE), .NUM_CMP(NC)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .wb        (bus.slave),
    .irq_o     (irq),
    .irq_any_o (irq_any)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: architectural registers and the bus response owed.
  logic [63:0] m_mtime, m_cmp [NC];
  logic [15:0] m_pcnt, m_div;
  logic        m_run, m_ack, m_err;
  logic [31:0] m_ie, m_pend, m_shadow, m_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] sel);
    logic [31:0] r = old_v;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Advance one clock: predict next model state from current drive, then compare outputs.
  task automatic step();
    logic [63:0] n_mtime, n_cmp [NC];
    logic [15:0] n_pcnt, n_div;
    logic        n_run, n_ack, n_err, acc, bad, tick;
    logic [31:0] n_ie, n_pend, n_shadow, n_rdata, off, d, w1c, set, ctrl, exp_irq;
    int unsigned idx;
    if (!rst_n) begin
      n_mtime = '0; n_pcnt = '0; n_shadow = '0; n_run = 1'b1; n_div = '0;
      n_ie = '0; n_pend = '0; n_ack = 1'b0; n_err = 1'b0; n_rdata = '0;
      for (int n = 0; n < NC; n++) n_cmp[n] = '1;
    end else begin
      tick    = m_run && (m_pcnt == m_div);
      n_mtime = m_mtime + (tick ? 64'd1 : 64'd0);
      n_pcnt  = !m_run ? m_pcnt : (tick ? 16'd0 : m_pcnt + 16'd1);
      n_run = m_run; n_div = m_div; n_ie = m_ie; n_shadow = m_shadow; n_cmp = m_cmp;
      n_ack = 1'b0; n_err = 1'b0; n_rdata = '0; w1c = '0; set = '0;
      for (int n = 0; n < NC; n++) if (m_mtime >= m_cmp[n]) set[n] = 1'b1;
      off = bus.adr_i - BASE;
      d   = bus.dat_i;
      acc = bus.stb_i && bus.cyc_i && !m_ack && !m_err && (bus.adr_i >= BASE) && (off < WIN);
      bad = (off % 4 != 0) || (off >= 32'h14 && off < 32'h20);
      if (acc && bad) n_err = 1'b1;
      if (acc && !bad) begin
        n_ack = 1'b1;
        idx = (off - 32) / 8;
        if (bus.we_i) begin
          case (off)
            R_LO:   n_mtime[31:0]  = merge32(n_mtime[31:0], d, bus.sel_i);
            R_HI:   n_mtime[63:32] = merge32(n_mtime[63:32], d, bus.sel_i);
            R_CTRL: begin
              ctrl   = merge32({m_div, 15'd0, m_run}, d, bus.sel_i);
              n_run  = ctrl[0];
              n_div  = ctrl[31:16];
              n_pcnt = '0;
            end
            R_IE:   n_ie = merge32(m_ie, d, bus.sel_i) & LOW;
            R_PEND: w1c  = merge32('0, d, bus.sel_i) & LOW;
            default:
              if ((off - 32) % 8 == 0) n_cmp[idx][31:0] = merge32(m_cmp[idx][31:0], d, bus.sel_i);
              else                     n_cmp[idx][63:32] = merge32(m_cmp[idx][63:32], d, bus.sel_i);
          endcase
        end else begin
          case (off)
            R_LO:   begin n_rdata = m_mtime[31:0]; n_shadow = m_mtime[63:32]; end
            R_HI:   n_rdata = m_shadow;
            R_CTRL: n_rdata = {m_div, 15'd0, m_run};
            R_IE:   n_rdata = m_ie;
            R_PEND: n_rdata = m_pend;
            default: n_rdata = ((off - 32) % 8 == 0) ? m_cmp[idx][31:0] : m_cmp[idx][63:32];
          endcase
        end
      end
      n_pend = (m_pend & ~w1c) | set;
    end
    @(posedge clk);
    m_mtime = n_mtime; m_pcnt = n_pcnt; m_shadow = n_shadow; m_run = n_run; m_div = n_div;
    m_ie = n_ie; m_pend = n_pend; m_cmp = n_cmp; m_ack = n_ack; m_err = n_err; m_rdata = n_rdata;
    #1;
    exp_irq = m_pend & m_ie & LOW;
    check("ack", bus.ack_o, m_ack);
    check("err", bus.err_o, m_err);
    check("rty", bus.rty_o, 1'b0);
    check("dat", bus.dat_o, (m_ack && !bus.we_i) ? m_rdata : 32'h0);
    check("irq", irq, exp_irq[NC-1:0]);
    check("irq_any", irq_any, exp_irq != 0);
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) step();
  endtask

  task automatic xfer(input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat,
                      input logic we, output logic [31:0] rd, output logic [1:0] resp);
    bus.adr_i = adr; bus.sel_i = sel; bus.dat_i = dat; bus.we_i = we;
    bus.stb_i = 1'b1; bus.cyc_i = 1'b1;
    step();
    rd   = bus.dat_o;
    resp = {bus.err_o, bus.ack_o};
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0; bus.we_i = 1'b0;
    step();
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] dat);
    logic [31:0] rd; logic [1:0] resp;
    xfer(BASE + off, 4'hF, dat, 1'b1, rd, resp);
  endtask

  task automatic rdr(input logic [31:0] off, output logic [31:0] val);
    logic [1:0] resp;
    xfer(BASE + off, 4'hF, 32'h0, 1'b0, val, resp);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [31:0] a, b, rd, adr, dat, lo, hi;
    logic [1:0]  resp;
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0; bus.we_i = 1'b0;
    bus.adr_i = '0; bus.sel_i = '0; bus.dat_i = '0;

    // Reset, with a request in flight that must be dropped.
    step();
    bus.adr_i = BASE + R_CTRL; bus.sel_i = 4'hF; bus.stb_i = 1'b1; bus.cyc_i = 1'b1;
    idle(2);
    bus.stb_i = 1'b0; bus.cyc_i = 1'b0;
    rst_n = 1'b1;
    idle(10);
    rdr(R_LO, a);
    check("boot_mtime", (a >= 9 && a <= 11), 1'b1);
    check("boot_irq", irq, '0);
    rdr(R_CTRL, a);
    check("rst_ctrl", a, 32'h0000_0001);
    rdr(32'h24 + 8 * (NC - 1), a);
    check("rst_cmp_hi", a, 32'hFFFF_FFFF);

    // Prescaler DIV=3, then freeze.
    wr(R_CTRL, 32'h0003_0001);
    rdr(R_LO, a);
    idle(40);
    rdr(R_LO, b);
    check("div3_rate", (b - a == 10) || (b - a == 11), 1'b1);
    wr(R_CTRL, 32'h0);
    rdr(R_LO, a);
    idle(20);
    rdr(R_LO, b);
    check("frozen", b - a, 32'h0);

    // Atomic LO/HI read across the 32-bit carry.
    wr(R_CTRL, 32'h1);
    for (int i = 0; i < 4; i++) begin
      wr(R_HI, 32'h0);
      wr(R_LO, 32'hFFFF_FFFE);
      idle($urandom_range(0, 3));
      rdr(R_LO, lo);
      rdr(R_HI, hi);
      check("carry_pair", (hi == 0 && lo >= 32'hFFFF_FFFE) || (hi == 1 && lo < 32'h100), 1'b1);
    end

    // Compare channel 2, set-wins W1C, IE masking.
    wr(R_HI, 32'h0);
    wr(R_LO, 32'h0);
    wr(32'h30, 32'd100);
    wr(32'h34, 32'h0);
    wr(R_IE, 32'h4);
    idle(120);
    check("irq_cmp2", irq, 4'b0100);
    wr(R_PEND, 32'h4);
    check("w1c_set_wins", irq, 4'b0100);
    wr(R_IE, 32'h0);
    rdr(R_PEND, a);
    check("pend_masked", a, 32'h4);
    check("irq_masked", irq, 4'b0000);
    wr(R_IE, 32'h4);
    wr(32'h30, 32'hFFFF_FFFF);
    wr(32'h34, 32'hFFFF_FFFF);
    wr(R_PEND, 32'h4);
    check("irq_cleared", irq, 4'b0000);

    // Error and unaddressed accesses.
    xfer(BASE + 32'h14, 4'hF, 32'hFFFF_FFFF, 1'b1, rd, resp);
    check("err_0x14", resp, 2'b10);
    xfer(BASE + 32'h02, 4'hF, 32'h0, 1'b0, rd, resp);
    check("err_0x02", resp, 2'b10);
    xfer(BASE + WIN, 4'hF, 32'hFFFF_FFFF, 1'b1, rd, resp);
    check("no_resp_win", resp, 2'b00);
    xfer(BASE - 4, 4'hF, 32'h0, 1'b0, rd, resp);
    check("no_resp_below", resp, 2'b00);
    rdr(R_IE, a);
    check("ie_unchanged", a, 32'h4);

    // Single byte lane write.
    xfer(BASE + 32'h20, 4'b0010, 32'hAABB_CCDD, 1'b1, rd, resp);
    rdr(32'h20, a);
    check("byte_lane", a, 32'hFFFF_CCFF);

    // Random register traffic against the model.
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 9))
        0:       adr = BASE + WIN + 4 * $urandom_range(0, 3);
        1:       adr = BASE - 4 * $urandom_range(1, 4);
        2:       adr = BASE + 4 * $urandom_range(0, WIN / 4 - 1) + $urandom_range(1, 3);
        default: adr = BASE + 4 * $urandom_range(0, WIN / 4 - 1);
      endcase
      dat = $urandom_range(0, 1) ? $urandom_range(0, 400) : $urandom;
      xfer(adr, 4'($urandom), dat, 1'($urandom), rd, resp);
      idle($urandom_range(0, 4));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
